// File: rtl/video_out_h_mag.sv
// video_out_h_mag: captures VDP lines into a double line buffer and replays the previous
// line with fractional horizontal magnification, left offset and linear interpolation.
module video_out_h_mag #(
    parameter int H_WR_START  = 224,
    parameter int LINE_PIXELS = 512,
    parameter int H_OUT_START = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [10:0] vdp_hcounter,
    input  logic [1:0]  vdp_vcounter,
    input  logic [10:0] h_cnt,
    input  logic [5:0]  vdp_r,
    input  logic [5:0]  vdp_g,
    input  logic [5:0]  vdp_b,
    output logic [7:0]  video_r,
    output logic [7:0]  video_g,
    output logic [7:0]  video_b,
    input  logic [7:0]  reg_left_offset,
    input  logic [7:0]  reg_denominator,
    input  logic [7:0]  reg_normalize
);
    localparam int AW = $clog2(LINE_PIXELS);

    // Even and odd source pixels live in separate RAMs so P0/P1 are fetched in one cycle.
    logic [17:0]   mem_e [LINE_PIXELS];
    logic [17:0]   mem_o [LINE_PIXELS];
    logic          wr_en;
    logic [AW-1:0] wr_px;
    logic [AW-2:0] ra_e, ra_o;
    logic [17:0]   rd_e_d, rd_o_d, rd_e_q, rd_o_q;
    logic          unused_ok;

    logic          open, in0, step;
    logic [AW-1:0] src0, src_d, src_q;
    logic [7:0]    acc0, acc_d, acc_q, d_d, d_q, n_d, n_q;
    logic [8:0]    acc_sum;
    logic          win_d, win_q;

    logic          in1_q, par1_q, last1_q;
    logic [7:0]    acc1_q, den1_q, nrm1_q;
    logic [17:0]   p0, p1;
    logic [7:0]    w0;
    logic [15:0]   sr_d, sg_d, sb_d, sr_q, sg_q, sb_q;
    logic          in2_q;
    logic [7:0]    nrm2_q;
    logic [9:0]    yr_d, yg_d, yb_d, yr_q, yg_q, yb_q;
    logic          in3_q;
    logic [7:0]    video_r_d, video_g_d, video_b_d, video_r_q, video_g_q, video_b_q;

    function automatic logic [15:0] blend(input logic [5:0] a, input logic [5:0] b,
                                          input logic [7:0] wa, input logic [7:0] wb);
        return ({8'd0, a, a[5:4]} * {8'd0, wa}) + ({8'd0, b, b[5:4]} * {8'd0, wb});
    endfunction

    function automatic logic [9:0] scale(input logic [15:0] s, input logic [7:0] n);
        return 10'(({9'd0, s} * {17'd0, n}) >> 15);
    endfunction

    function automatic logic [7:0] sat(input logic [9:0] y);
        return (y > 10'd255) ? 8'hFF : y[7:0];
    endfunction

    assign unused_ok = vdp_vcounter[1];

    always_comb begin
        wr_en   = enable && !vdp_hcounter[0] && vdp_hcounter >= 11'(H_WR_START)
                  && vdp_hcounter < 11'(H_WR_START + 2 * LINE_PIXELS);
        wr_px   = AW'((vdp_hcounter - 11'(H_WR_START)) >> 1);
        open    = h_cnt == 11'(H_OUT_START) + {3'd0, reg_left_offset};
        in0     = open || win_q;
        src0    = open ? '0 : src_q;
        acc0    = open ? '0 : acc_q;
        d_d     = open ? reg_denominator : d_q;
        n_d     = open ? reg_normalize : n_q;
        acc_sum = {1'b0, acc0} + 9'd128;
        step    = acc_sum >= {1'b0, d_d};
        acc_d   = step ? 8'(acc_sum - {1'b0, d_d}) : acc_sum[7:0];
        src_d   = src0 + {{(AW-1){1'b0}}, step};
        win_d   = in0 && !(step && src0 == AW'(LINE_PIXELS - 1));
        ra_o    = src0[AW-1:1];
        ra_e    = src0[AW-1:1] + {{(AW-2){1'b0}}, src0[0]};
        rd_e_d  = mem_e[{~vdp_vcounter[0], ra_e}];
        rd_o_d  = mem_o[{~vdp_vcounter[0], ra_o}];
    end

    always_comb begin
        p0        = par1_q ? rd_o_q : rd_e_q;
        p1        = last1_q ? p0 : (par1_q ? rd_e_q : rd_o_q);
        w0        = den1_q - acc1_q;
        sr_d      = blend(p0[17:12], p1[17:12], w0, acc1_q);
        sg_d      = blend(p0[11:6], p1[11:6], w0, acc1_q);
        sb_d      = blend(p0[5:0], p1[5:0], w0, acc1_q);
        yr_d      = scale(sr_q, nrm2_q);
        yg_d      = scale(sg_q, nrm2_q);
        yb_d      = scale(sb_q, nrm2_q);
        video_r_d = in3_q ? sat(yr_q) : '0;
        video_g_d = in3_q ? sat(yg_q) : '0;
        video_b_d = in3_q ? sat(yb_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !wr_px[0])
            mem_e[{vdp_vcounter[0], wr_px[AW-1:1]}] <= {vdp_r, vdp_g, vdp_b};
        if (wr_en && wr_px[0])
            mem_o[{vdp_vcounter[0], wr_px[AW-1:1]}] <= {vdp_r, vdp_g, vdp_b};
        rd_e_q <= rd_e_d;
        rd_o_q <= rd_o_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q     <= 1'b0;
            src_q     <= '0;
            acc_q     <= '0;
            d_q       <= '0;
            n_q       <= '0;
            in1_q     <= 1'b0;
            par1_q    <= 1'b0;
            last1_q   <= 1'b0;
            acc1_q    <= '0;
            den1_q    <= '0;
            nrm1_q    <= '0;
            sr_q      <= '0;
            sg_q      <= '0;
            sb_q      <= '0;
            in2_q     <= 1'b0;
            nrm2_q    <= '0;
            yr_q      <= '0;
            yg_q      <= '0;
            yb_q      <= '0;
            in3_q     <= 1'b0;
            video_r_q <= '0;
            video_g_q <= '0;
            video_b_q <= '0;
        end else begin
            win_q     <= win_d;
            src_q     <= src_d;
            acc_q     <= acc_d;
            d_q       <= d_d;
            n_q       <= n_d;
            in1_q     <= in0;
            par1_q    <= src0[0];
            last1_q   <= src0 == AW'(LINE_PIXELS - 1);
            acc1_q    <= acc0;
            den1_q    <= d_d;
            nrm1_q    <= n_d;
            sr_q      <= sr_d;
            sg_q      <= sg_d;
            sb_q      <= sb_d;
            in2_q     <= in1_q;
            nrm2_q    <= nrm1_q;
            yr_q      <= yr_d;
            yg_q      <= yg_d;
            yb_q      <= yb_d;
            in3_q     <= in2_q;
            video_r_q <= video_r_d;
            video_g_q <= video_g_d;
            video_b_q <= video_b_d;
        end
    end

    assign video_r = video_r_q;
    assign video_g = video_g_q;
    assign video_b = video_b_q;
endmodule

// File: tb/tb_video_out_h_mag.sv
// tb_video_out_h_mag: line-by-line randomized stimulus, expected pixels queued from an
// arithmetic model of the magnifier and compared by an independent monitor.
module tb_video_out_h_mag;
    localparam int NL = 16;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [10:0] vdp_hcounter, h_cnt;
    logic [1:0]  vdp_vcounter;
    logic [5:0]  vdp_r, vdp_g, vdp_b;
    logic [7:0]  video_r, video_g, video_b;
    logic [7:0]  reg_left_offset, reg_denominator, reg_normalize;

    typedef struct {
        int          cyc;
        bit          chk;
        logic [23:0] exp;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0, errors = 0, edge_n = 0, cur_line = 0;
    int          nz [NL];
    bit          rst_hist [int];
    logic [17:0] mem [2][512];
    bit          bank_ok [2];
    logic [17:0] line_px [512];
    bit          win = 1'b0;
    int          k, md, mn;

    always #5 clk = ~clk;

    video_out_h_mag dut (
        .clk(clk), .reset(reset), .enable(enable),
        .vdp_hcounter(vdp_hcounter), .vdp_vcounter(vdp_vcounter), .h_cnt(h_cnt),
        .vdp_r(vdp_r), .vdp_g(vdp_g), .vdp_b(vdp_b),
        .video_r(video_r), .video_g(video_g), .video_b(video_b),
        .reg_left_offset(reg_left_offset), .reg_denominator(reg_denominator),
        .reg_normalize(reg_normalize)
    );

    function automatic int interp(input int a, input int b, input int d, input int acc, input int n);
        int ea, eb, y;
        ea = a * 4 + a / 16;
        eb = b * 4 + b / 16;
        y  = ((ea * (d - acc) + eb * acc) * n) / 32768;
        return (y > 255) ? 255 : y;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        rst_hist[edge_n] = reset;
    end

    always @(negedge clk) begin
        exp_t e;
        bit   masked;
        if (rst_hist.exists(edge_n) && rst_hist[edge_n]) begin
            checks++;
            if ({video_r, video_g, video_b} != 24'h0) begin
                errors++;
                $display("FAIL reset_out edge=%0d got=%06h exp=000000", edge_n, {video_r, video_g, video_b});
            end
        end
        if (video_r != 8'h0) nz[cur_line]++;
        while (sbq.size() > 0 && sbq[0].cyc + 4 <= edge_n) begin
            e = sbq.pop_front();
            masked = 1'b0;
            for (int i = 1; i <= 4; i++)
                if (rst_hist.exists(e.cyc + i) && rst_hist[e.cyc + i]) masked = 1'b1;
            if (masked) e.exp = '0;
            if (e.chk || masked) begin
                checks++;
                if ({video_r, video_g, video_b} != e.exp) begin
                    errors++;
                    $display("FAIL pixel cyc=%0d line=%0d got=%06h exp=%06h", e.cyc, cur_line,
                             {video_r, video_g, video_b}, e.exp);
                end
            end
        end
    end

    task automatic drive(input bit rst, input bit en, input int hc, input int lclk, input int vc,
                         input int off, input int den, input int nrm);
        exp_t        e;
        int          idx, src, acc, rb;
        logic [17:0] q0, q1;
        bit          wr;
        @(posedge clk);
        #1;
        reset           = rst;
        enable          = en;
        vdp_hcounter    = 11'(hc);
        vdp_vcounter    = 2'(vc);
        h_cnt           = (lclk > 2047) ? 11'd2047 : 11'(lclk);
        reg_left_offset = 8'(off);
        reg_denominator = 8'(den);
        reg_normalize   = 8'(nrm);
        idx = (hc - 224) / 2;
        wr  = en && (hc % 2 == 0) && hc >= 224 && hc < 1248;
        {vdp_r, vdp_g, vdp_b} = wr ? line_px[idx] : 18'($urandom);
        e.cyc = edge_n;
        e.chk = 1'b1;
        e.exp = '0;
        if (rst) win = 1'b0;
        else begin
            if (int'(h_cnt) == 160 + off) begin
                win = 1'b1;
                k   = 0;
                md  = den;
                mn  = nrm;
            end
            if (win) begin
                src = (128 * k) / md;
                acc = (128 * k) % md;
                if (src >= 512) win = 1'b0;
                else begin
                    rb    = (vc % 2 == 1) ? 0 : 1;
                    q0    = mem[rb][src];
                    q1    = (src == 511) ? q0 : mem[rb][src + 1];
                    e.chk = bank_ok[rb];
                    e.exp = {8'(interp(int'(q0[17:12]), int'(q1[17:12]), md, acc, mn)),
                             8'(interp(int'(q0[11:6]), int'(q1[11:6]), md, acc, mn)),
                             8'(interp(int'(q0[5:0]), int'(q1[5:0]), md, acc, mn))};
                    k++;
                end
            end
        end
        sbq.push_back(e);
        if (wr) begin
            mem[vc % 2][idx] = line_px[idx];
            if (idx == 511) bank_ok[vc % 2] = 1'b1;
        end
    endtask

    task automatic check_nz(input int ln, input int want);
        checks++;
        if (nz[ln] != want) begin
            errors++;
            $display("FAIL window_len line=%0d got=%0d exp=%0d", ln, nz[ln], want);
        end
    endtask

    initial begin
        int pat, off, den, nrm, lclk;
        logic [17:0] colour;
        reset           = 1'b1;
        enable          = 1'b0;
        vdp_hcounter    = '0;
        vdp_vcounter    = '0;
        h_cnt           = '0;
        {vdp_r, vdp_g, vdp_b} = '0;
        reg_left_offset = 8'd0;
        reg_denominator = 8'd180;
        reg_normalize   = 8'd182;
        for (int ln = 0; ln < NL; ln++) begin
            cur_line = ln;
            case (ln)
                0, 1:    begin pat = 0; den = 180; off = 0;   end
                2:       begin pat = 1; den = 144; off = 30;  end
                3:       begin pat = 0; den = 200; off = 57;  end
                4:       begin pat = 2; den = 200; off = 0;   end
                5:       begin pat = 2; den = 180; off = 0;   end
                6:       begin pat = 3; den = 180; off = 112; end
                default: begin
                    pat = $urandom_range(4, 2);
                    den = $urandom_range(200, 144);
                    off = $urandom_range(112, 0);
                end
            endcase
            nrm    = 32768 / den;
            colour = 18'($urandom);
            for (int i = 0; i < 512; i++) begin
                case (pat)
                    0:       line_px[i] = 18'h3FFFF;
                    1:       line_px[i] = 18'h0;
                    2:       line_px[i] = (i % 7 < 3) ? 18'h3FFFF : 18'h0;
                    3:       line_px[i] = 18'($urandom);
                    default: line_px[i] = colour;
                endcase
            end
            lclk = 0;
            for (int h = 0; h < 1368; h++) begin
                for (int ph = 0; ph < 2; ph++) begin
                    if ((ln == 7 || ln == 8 || ln == 11) && lclk == 600) begin
                        den = $urandom_range(200, 144);
                        nrm = 32768 / den;
                    end
                    drive((ln == 0 && lclk < 2) || (ln == 9 && lclk >= 300 && lclk < 303),
                          ph == 0, h, lclk, ln, off, den, nrm);
                    lclk++;
                end
                if (ln == 10 && h == 400)
                    for (int j = 0; j < 40; j++) begin
                        drive(1'b0, 1'b0, h, lclk, ln, off, den, nrm);
                        lclk++;
                    end
            end
        end
        for (int j = 0; j < 8; j++) drive(1'b0, 1'b0, 0, 3000, NL, 0, 180, 182);
        check_nz(1, 720);
        check_nz(2, 576);
        check_nz(3, 0);
        check_nz(4, 800);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
